// File: rtl/regfile_sb.sv
// Multi-read-port register file with optional write bypass and a per-register
// busy scoreboard. Register 0 reads as zero and is never busy.

// One read port: index-0 masking, writeback forwarding and hazard flag.
module regfile_sb_rport #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic          rst_i,
  input  logic [AW-1:0] ra_i,
  input  logic [DW-1:0] reg_i,
  input  logic          busy_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  output logic [DW-1:0] rd_o,
  output logic          rbusy_o
);
  logic hit;
  assign hit = BYPASS && we_i && (wa_i == ra_i) && (ra_i != '0);

  // Outputs are forced low while reset is held so forwarded data cannot leak.
  always_comb begin
    rd_o    = '0;
    rbusy_o = 1'b0;
    if (!rst_i && ra_i != '0) begin
      rd_o    = hit ? wd_i : reg_i;
      rbusy_o = busy_i && !hit;
    end
  end
endmodule

module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           regwrite,
  input  logic [ADDR_WIDTH-1:0]          wa,
  input  logic [DATA_WIDTH-1:0]          wd,
  input  logic                           issue,
  input  logic [ADDR_WIDTH-1:0]          issue_dest,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd,
  output logic [NUM_READ-1:0]            rbusy,
  output logic [ADDR_WIDTH:0]            busy_count
);
  localparam int DW    = DATA_WIDTH;
  localparam int AW    = ADDR_WIDTH;
  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0][DW-1:0] regs_q;
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [AW:0]              cnt_q, cnt_d;

  // Register array; index 0 is never written so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '0;
    else if (regwrite && wa != '0) regs_q[wa] <= wd;
  end

  // Next busy state: writeback clears, issue sets afterwards so set wins.
  always_comb begin
    busy_d = busy_q;
    if (regwrite) busy_d[wa] = 1'b0;
    if (issue)    busy_d[issue_dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Population count of the next busy vector, registered alongside it.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
  end

  // Scoreboard and its count update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_count = cnt_q;

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rp
    logic [AW-1:0] ra_g;
    assign ra_g = ra[g*AW +: AW];
    regfile_sb_rport #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_rp (
      .rst_i   (reset),
      .ra_i    (ra_g),
      .reg_i   (regs_q[ra_g]),
      .busy_i  (busy_q[ra_g]),
      .we_i    (regwrite),
      .wa_i    (wa),
      .wd_i    (wd),
      .rd_o    (rd[g*DW +: DW]),
      .rbusy_o (rbusy[g])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: two register files (forwarding on / off) share stimulus;
// expected outputs come from an array model and are checked by a monitor.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        regwrite = 1'b0, issue = 1'b0;
  logic [4:0]  wa = '0, issue_dest = '0;
  logic [31:0] wd = '0;
  logic [14:0] ra = '0;
  logic [95:0] rd1, rd0;
  logic [2:0]  rb1, rb0;
  logic [5:0]  cnt1, cnt0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(3), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .regwrite(regwrite), .wa(wa), .wd(wd),
    .issue(issue), .issue_dest(issue_dest), .ra(ra),
    .rd(rd1), .rbusy(rb1), .busy_count(cnt1));

  regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(3), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .regwrite(regwrite), .wa(wa), .wd(wd),
    .issue(issue), .issue_dest(issue_dest), .ra(ra),
    .rd(rd0), .rbusy(rb0), .busy_count(cnt0));

  typedef struct {
    logic [95:0] rd1, rd0;
    logic [2:0]  rb1, rb0;
    logic [5:0]  cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  // reference model state
  logic [31:0] regs_m [32];
  bit          busy_m [32];

  function automatic logic [31:0] m_rd(bit bp, logic [4:0] a);
    if (reset || a == 0) return 32'h0;
    if (bp && regwrite && wa == a) return wd;
    return regs_m[a];
  endfunction

  function automatic logic m_rb(bit bp, logic [4:0] a);
    if (reset || a == 0) return 1'b0;
    return busy_m[a] && !(bp && regwrite && wa == a);
  endfunction

  function automatic logic [5:0] m_cnt();
    int n = 0;
    foreach (busy_m[i]) n += int'(busy_m[i]);
    return 6'(n);
  endfunction

  task automatic chk(string nm, logic [95:0] got, logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  // Monitor: outputs are combinational/registered and valid every cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_bp1",    rd1,          e.rd1);
      chk("rd_bp0",    rd0,          e.rd0);
      chk("rbusy_bp1", {93'h0, rb1}, {93'h0, e.rb1});
      chk("rbusy_bp0", {93'h0, rb0}, {93'h0, e.rb0});
      chk("cnt_bp1",   {90'h0, cnt1}, {90'h0, e.cnt});
      chk("cnt_bp0",   {90'h0, cnt0}, {90'h0, e.cnt});
    end
  end

  // Drive one cycle of stimulus, queue the expectation, then advance the model.
  task automatic cyc(input logic rw, input logic [4:0] a_wa, input logic [31:0] a_wd,
                     input logic iss, input logic [4:0] idst,
                     input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                     input logic rst);
    exp_t e;
    logic [4:0] rv [3];
    reset = rst; regwrite = rw; wa = a_wa; wd = a_wd;
    issue = iss; issue_dest = idst; ra = {r2, r1, r0};
    rv[0] = r0; rv[1] = r1; rv[2] = r2;
    if (rst) begin
      foreach (regs_m[i]) begin regs_m[i] = '0; busy_m[i] = 1'b0; end
    end
    for (int p = 0; p < 3; p++) begin
      e.rd1[p*32 +: 32] = m_rd(1'b1, rv[p]);
      e.rd0[p*32 +: 32] = m_rd(1'b0, rv[p]);
      e.rb1[p] = m_rb(1'b1, rv[p]);
      e.rb0[p] = m_rb(1'b0, rv[p]);
    end
    e.cnt = m_cnt();
    q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      if (rw && a_wa != 0) regs_m[a_wa] = a_wd;
      if (rw) busy_m[a_wa] = 1'b0;
      if (iss) busy_m[idst] = 1'b1;
      busy_m[0] = 1'b0;
    end
    #1;
  endtask

  function automatic logic [4:0] ad();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    foreach (regs_m[i]) begin regs_m[i] = '0; busy_m[i] = 1'b0; end
    @(posedge clk); #1;
    cyc(1, 5'd5, 32'h1111, 1, 5'd5, 5, 5, 0, 1);
    cyc(0, 0, 0, 0, 0, 5, 1, 2, 1);
    // write reg5, then async reset mid-cycle while bypassing reg5
    cyc(1, 5'd5, 32'hDEADBEEF, 1, 5'd6, 5, 6, 0, 0);
    cyc(0, 0, 0, 0, 0, 5, 6, 5, 0);
    cyc(1, 5'd5, 32'hCAFE0001, 0, 0, 5, 6, 0, 1);
    cyc(0, 0, 0, 0, 0, 5, 6, 5, 0);
    // write to register 0 ignored
    cyc(1, 5'd0, 32'h1234, 1, 5'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // bypass vs non-bypass of reg7
    cyc(1, 5'd7, 32'h0BAD0BAD, 0, 0, 7, 7, 7, 0);
    cyc(1, 5'd7, 32'hA5A5A5A5, 0, 0, 7, 0, 7, 0);
    cyc(0, 0, 0, 0, 0, 7, 7, 0, 0);
    // issue 3, hazard, writeback clears
    cyc(0, 0, 0, 1, 5'd3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 3, 0, 0);
    cyc(1, 5'd3, 32'h33, 0, 0, 0, 3, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 3, 3, 0);
    // same-cycle issue and writeback on 9: set wins
    cyc(1, 5'd9, 32'h99, 1, 5'd9, 9, 9, 0, 0);
    cyc(0, 0, 0, 0, 0, 9, 9, 0, 0);
    // issue 1..31 back to back, then count saturates at 31
    for (int r = 1; r < 32; r++) cyc(0, 0, 0, 1, 5'(r), 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5'd4, 0, 31, 31, 0);
    cyc(0, 0, 0, 0, 0, 0, 31, 31, 0);
    // randomized traffic with occasional resets
    for (int n = 0; n < 800; n++)
      cyc(1'($urandom_range(0, 1)), ad(), $urandom(), 1'($urandom_range(0, 1)), ad(),
          ad(), ad(), ad(), ($urandom_range(0, 59) == 0));
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
